// File: rtl/div_radix2_pkg.sv
// div_radix2_pkg: FSM state codes and handshake constants for the divider.
// Both the EX stage and the divider import this package so they share one
// encoding.
package div_radix2_pkg;

  // Divider FSM states.
  typedef enum logic [1:0] {
    DivFree   = 2'b00,  // idle, waiting for start_i
    DivByZero = 2'b01,  // divisor was zero, result is forced to zero
    DivOn     = 2'b10,  // iterating, one quotient bit per cycle
    DivEnd    = 2'b11   // result presented, waiting for start_i to drop
  } div_state_e;

  // Handshake levels seen on start_i and ready_o.
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  // Default operand width and the matching all-zero word.
  localparam int          DivWidth = 32;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  // Magnitude of a two's-complement word when treated as signed.
  // The most negative value maps onto itself, which is still the correct
  // unsigned magnitude.
  function automatic logic [DivWidth-1:0] div_abs(input logic [DivWidth-1:0] v,
                                                  input logic               is_signed);
    if (is_signed && v[DivWidth-1]) begin
      return ZeroWord - v;
    end
    return v;
  endfunction

endpackage

// File: rtl/div_radix2_step_r2.sv
// div_radix2_step_r2: one restoring radix-2 division step.
// Latency: combinational. Backpressure: none; it is pure logic.
// Ports:
//   rem_i     current partial remainder (always < divisor_i)
//   dvd_bit_i next dividend bit, shifted into the partial remainder LSB
//   divisor_i divisor magnitude
//   rem_o     new partial remainder
//   q_bit_o   quotient bit produced by this step
module div_radix2_step_r2 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvd_bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             no_borrow;

  always_comb begin
    shifted   = {rem_i, dvd_bit_i};
    no_borrow = (shifted >= {1'b0, divisor_i});
    // When no borrow occurs the true difference is below the divisor, so
    // it fits in WIDTH bits. That makes a modulo-2^WIDTH subtraction exact.
    diff      = shifted[WIDTH-1:0] - divisor_i;
    rem_o     = no_borrow ? diff : shifted[WIDTH-1:0];
    q_bit_o   = no_borrow;
  end

endmodule

// File: rtl/div_radix2.sv
// div_radix2: iterative restoring divider (DIV/DIVU, MIPS semantics) for the EX stage.
// Latency: ready_o is high after WIDTH+1 edges counting the sampling edge, or after 2 edges for divide-by-zero.
// Backpressure: start_i is held by EX; the result holds in END until start_i drops, and only one divide is in flight.
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   signed_div_i   1 = signed divide, sampled together with start_i
//   opdata1_i      dividend, sampled with start_i
//   opdata2_i      divisor, sampled with start_i
//   start_i        request, held high until ready_o is seen
//   annul_i        aborts the operation in FREE, BY_ZERO and ON
//   result_o       {remainder, quotient}, i.e. {HI, LO}
//   ready_o        result valid
module div_radix2
  import div_radix2_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_e       state;
  logic [CNT_W-1:0] cnt;
  // Dividend magnitude. It shifts left once per step, and quotient bits
  // enter at the LSB. After WIDTH steps the register holds the quotient.
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] divisor;
  logic             sgn_r;
  logic             s1_r;
  logic             s2_r;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] r_final;
  logic             neg_q;
  logic             neg_r;

  div_radix2_step_r2 #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i     (rem),
    .dvd_bit_i (dvd_q[WIDTH-1]),
    .divisor_i (divisor),
    .rem_o     (step_rem),
    .q_bit_o   (step_q)
  );

  always_comb begin
    a_mag = opdata1_i;
    b_mag = opdata2_i;
    if (signed_div_i && opdata1_i[WIDTH-1]) a_mag = -opdata1_i;
    if (signed_div_i && opdata2_i[WIDTH-1]) b_mag = -opdata2_i;

    // The last step's outputs are used directly, so the result is loaded on
    // the same edge that completes step WIDTH.
    q_final = {dvd_q[WIDTH-2:0], step_q};
    neg_q   = sgn_r && (s1_r ^ s2_r);  // quotient truncates toward zero
    neg_r   = sgn_r && s1_r;           // remainder takes the dividend's sign
    r_final = neg_r ? -step_rem : step_rem;
    if (neg_q) q_final = -q_final;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= DivFree;
      cnt      <= '0;
      dvd_q    <= '0;
      rem      <= '0;
      divisor  <= '0;
      sgn_r    <= 1'b0;
      s1_r     <= 1'b0;
      s2_r     <= 1'b0;
      result_o <= '0;
      ready_o  <= DivResultNotReady;
    end else begin
      case (state)
        DivFree: begin
          ready_o <= DivResultNotReady;
          // When start_i and annul_i are both high, annul wins.
          if (start_i == DivStart && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= DivByZero;
            end else begin
              dvd_q   <= a_mag;
              divisor <= b_mag;
              rem     <= '0;
              sgn_r   <= signed_div_i;
              s1_r    <= opdata1_i[WIDTH-1];
              s2_r    <= opdata2_i[WIDTH-1];
              cnt     <= '0;
              state   <= DivOn;
            end
          end
        end

        DivByZero: begin
          if (annul_i) begin
            state <= DivFree;
          end else begin
            result_o <= '0;
            ready_o  <= DivResultReady;
            state    <= DivEnd;
          end
        end

        DivOn: begin
          // An aborted divide leaves silently. No result is written and
          // ready_o stays low.
          if (annul_i || start_i == DivStop) begin
            state <= DivFree;
          end else begin
            rem   <= step_rem;
            dvd_q <= {dvd_q[WIDTH-2:0], step_q};
            cnt   <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) begin
              result_o <= {r_final, q_final};
              ready_o  <= DivResultReady;
              state    <= DivEnd;
            end
          end
        end

        DivEnd: begin
          // Hold the result until EX drops start_i. annul_i has no effect
          // here, and no new divide starts until start_i has been low.
          if (start_i == DivStop) begin
            result_o <= '0;
            ready_o  <= DivResultNotReady;
            state    <= DivFree;
          end
        end

        default: begin
          state <= DivFree;
        end
      endcase
    end
  end

endmodule

// File: doc/div_radix2.md
Name: div_radix2

Overview:
- Iterative 32-cycle radix-2 restoring divider. It is the responder to the EX-stage divide handshake.
- EX holds start_i with stable operands while stalling the pipeline. This block latches the operands, iterates, then raises ready_o with a 64-bit {remainder, quotient} result that EX writes to HI/LO.
- Supports signed (DIV) and unsigned (DIVU) with MIPS semantics. EX can abort a divide via annul_i.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH; iteration count = WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- signed_div_i  in  1  1 = signed divide; sampled with start_i.
- opdata1_i  in  WIDTH  dividend; sampled with start_i.
- opdata2_i  in  WIDTH  divisor; sampled with start_i.
- start_i  in  1  request; held high by EX until ready_o is seen.
- annul_i  in  1  abort the operation in progress.
- result_o  out  2*WIDTH  [2W-1:W] remainder (HI), [W-1:0] quotient (LO).
- ready_o  out  1  result valid.

Behaviour:
- Reset (async, rst=1): state=FREE, ready_o=0, result_o=0, counter=0, internal regs cleared. Reset mid-operation discards all progress.

FSM states: FREE, BY_ZERO, ON, END.
- FREE: on an edge with start_i=1 and annul_i=0:
  - divisor==0 -> BY_ZERO.
  - otherwise latch |dividend| and |divisor| (absolute value only if signed_div_i; 2's complement of 0x80000000 is 0x80000000, treated as unsigned magnitude).
  - Also latch signed_div_i and both operand sign bits; clear the counter; go to ON.
  - Operand changes after sampling are ignored.
- BY_ZERO: next edge -> END with result_o=0. annul_i=1 -> FREE.
- ON: one restoring step per cycle. Partial remainder shifts left by 1, bringing in the next dividend MSB; trial subtract of the divisor; if no borrow, keep the difference and quotient bit=1, else quotient bit=0. Counter +1.
  - annul_i=1 or start_i=0 -> FREE immediately, no result, ready_o stays 0.
  - On the edge completing step WIDTH: apply sign correction, load result_o, set ready_o=1, go to END.
- Sign correction (signed only):
  - quotient negated iff dividend sign != divisor sign.
  - remainder negated iff dividend negative.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
- END: ready_o=1; result_o holds.
  - start_i=0 -> FREE with ready_o=0 and result_o=0 on that edge.
  - start_i still high: stay in END; no restart without start_i first dropping.
  - annul_i ignored in END.
- Latency: counting the FREE sampling edge as edge 1, ready_o is high after edge WIDTH+1 (33 for WIDTH=32); divide-by-zero after edge 2. Throughput: one divide in flight.
- Overflow: signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0 (wraps, no exception).
- Simultaneous start_i and annul_i in FREE: annul wins, stay in FREE.
- ready_o is a registered output; result_o is registered.

Decomposition:
- Shared defines.vh holds the state codes DivFree/DivByZero/DivOn/DivEnd and the constants DivStart/DivStop, DivResultReady/DivResultNotReady and ZeroWord, so EX and this block share one encoding.
- One natural combinational sub-module, div_step_r2: takes partial remainder, next dividend bit and divisor; returns the new partial remainder and the quotient bit.

Test Plan:
- Unsigned 100/7, start held -> ready_o after 33 edges, result_o=0x00000002_0000000E; drop start -> next edge ready_o=0, result_o=0.
- Signed -7/2 (0xFFFFFFF9/0x00000002) -> result_o=0xFFFFFFFF_FFFFFFFD; signed 7/-2 -> remainder 1, quotient 0xFFFFFFFD.
- Divisor 0 (signed or unsigned) -> ready_o after edge 2, result_o=0; 0x80000000/0xFFFFFFFF signed -> 0x00000000_80000000; unsigned -> 0x80000000_00000000.
- annul_i pulsed at step 10 of ON -> FREE next edge, ready_o never rises; a new start then gives a correct result 33 edges later.
- rst asserted asynchronously mid-ON (between edges) -> ready_o=0, result_o=0 immediately; after release, 0xFFFFFFFF/0x10 unsigned -> 0x0000000F_0FFFFFFF.
- start_i held high in END for 3 cycles -> ready_o and result_o stable, no restart; operands changed during ON do not affect the result.
